// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, bus mode and idle levels.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int   SPI_MODE    = 0;
  localparam logic SPI_CPOL    = 1'(SPI_MODE >> 1);
  localparam int   CLK_DIV_MIN = 4;
  localparam logic CE_IDLE     = 1'b1;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK half-period generator: strobes at the end of each half-period while enabled.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic go,
  input  logic last,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam logic [7:0] HALF_END = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       tick;

  assign tick      = en && (cnt == HALF_END);
  assign rise_tick = tick && (sclk == SPI_CPOL);
  assign fall_tick = tick && (sclk != SPI_CPOL);

  // go launches the first high half-period; last keeps SCLK low through the closing low half
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= SPI_CPOL;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= go ? ~SPI_CPOL : SPI_CPOL;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= (last || (sclk != SPI_CPOL)) ? SPI_CPOL : ~SPI_CPOL;
    end else begin
      cnt  <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: WIDTH-bit MSB-first transfers to CE0/CE1 with start/busy/done handshake.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 6,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cs_sel,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             CE0,
  output logic             CE1
);

  localparam int         DIV    = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
  localparam int         BW     = $clog2(WIDTH) + 1;
  localparam logic [7:0] PH_END = 8'(DIV - 1);

  spi_state_t       state, state_nxt;
  logic [7:0]       ph_cnt;
  logic             ph_done;
  logic [BW-1:0]    bit_cnt;
  logic             last;
  logic [WIDTH-1:0] tx_sr, tx_nxt;
  logic [WIDTH-1:0] rx_sr, rx_nxt;
  logic             rise_tick, fall_tick;
  logic             accept, xfer_end, hold_end;

  assign ph_done  = (ph_cnt == PH_END);
  assign last     = (bit_cnt == BW'(WIDTH));
  assign accept   = (state == IDLE) && start;
  assign xfer_end = (state == XFER) && rise_tick && last;
  assign hold_end = (state == HOLD) && ph_done;
  assign tx_nxt   = tx_sr << 1;
  assign rx_nxt   = (rx_sr << 1) | WIDTH'(MISO);

  spi_clkgen #(
    .CLK_DIV (DIV)
  ) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .en        (state == XFER),
    .go        ((state == SETUP) && ph_done),
    .last      (last),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (SCLK)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SETUP;
      SETUP:   if (ph_done)  state_nxt = XFER;
      XFER:    if (xfer_end) state_nxt = HOLD;
      HOLD:    if (ph_done)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // SETUP and HOLD each last one half-period, timed here rather than in the clock generator
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ph_cnt <= '0;
    else if (((state == SETUP) || (state == HOLD)) && !ph_done)
      ph_cnt <= ph_cnt + 8'd1;
    else
      ph_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            bit_cnt <= '0;
    else if (accept)    bit_cnt <= '0;
    else if (fall_tick) bit_cnt <= bit_cnt + BW'(1);
  end

  // Bus-facing and handshake registers; every output is driven straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      CE0     <= CE_IDLE;
      CE1     <= CE_IDLE;
      MOSI    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy <= 1'b1;
        CE0  <= cs_sel ? CE_IDLE : ~CE_IDLE;
        CE1  <= cs_sel ? ~CE_IDLE : CE_IDLE;
        MOSI <= tx_data[WIDTH-1];
      end else if (fall_tick) begin
        MOSI <= tx_nxt[WIDTH-1];
      end else if (xfer_end) begin
        MOSI <= 1'b0;
      end else if (hold_end) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        CE0     <= CE_IDLE;
        CE1     <= CE_IDLE;
        rx_data <= rx_sr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)         tx_sr <= tx_data;
    else if (fall_tick) tx_sr <= tx_nxt;
    if (fall_tick)      rx_sr <= rx_nxt;
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: default 6/8 instance plus a CLK_DIV=4, WIDTH=1 instance.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start, cs_sel;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, sclk, mosi, miso, ce0, ce1;

  logic       start_b, cs_b, misob;
  logic [0:0] txb, rxb;
  logic       busy_b, done_b, sclk_b, mosi_b, ce0_b, ce1_b;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(6), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cs_sel(cs_sel), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso), .CE0(ce0), .CE1(ce1)
  );

  spi_master #(.CLK_DIV(4), .WIDTH(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cs_sel(cs_b), .tx_data(txb),
    .rx_data(rxb), .busy(busy_b), .done(done_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .MISO(misob), .CE0(ce0_b), .CE1(ce1_b)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic       cs;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         mode = 0;
  logic [7:0] pat = 8'h3C;
  int         fall_cnt = 0;
  int         rise_cnt = 0;
  int         done_cnt = 0;
  int         t0 = 0;
  logic [7:0] mosi_cap = '0;
  logic       unsel_low = 1'b0;
  logic       sel = 1'b0;
  logic       active = 1'b0;
  logic       prev_sclk = 1'b0;
  logic       resp_bit;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder presents pat MSB-first, advancing after each SCLK fall
  assign resp_bit = (fall_cnt < 8) ? pat[7 - fall_cnt] : 1'b0;
  assign miso     = (mode == 1) ? resp_bit : mosi;
  assign misob    = 1'b1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_done(input string name, input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(name, 0, 1);
  endtask

  task automatic issue(input logic [7:0] tx, input logic cs, input logic [7:0] rx);
    exp_t e;
    @(posedge clk); #1;
    tx_data = tx;
    cs_sel  = cs;
    start   = 1'b1;
    e.tx = tx; e.rx = rx; e.cs = cs;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic cs, input logic [7:0] rx);
    issue(tx, cs, rx);
    wait_done("done_timeout", 200);
  endtask

  // Monitor: bus observation and scoreboard pop on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        active   = 1'b0;
        fall_cnt = 0;
      end else begin
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", int'(rx_data), int'(e.rx));
            chk("latency", cyc - t0, 109);
            chk("sclk_rises", rise_cnt, 8);
            chk("mosi_bits", int'(mosi_cap), int'(e.tx));
            chk("unsel_ce_low", int'(unsel_low), 0);
            chk("sel_ce_high_at_done", int'(e.cs ? ce1 : ce0), 1);
          end
          active = 1'b0;
        end
        if (sclk && !prev_sclk) begin
          rise_cnt++;
          mosi_cap = {mosi_cap[6:0], mosi};
        end
        if (!sclk && prev_sclk) fall_cnt++;
        if (active && ((sel ? ce0 : ce1) == 1'b0)) unsel_low = 1'b1;
        if (start && !busy) begin
          t0        = cyc;
          rise_cnt  = 0;
          fall_cnt  = 0;
          mosi_cap  = '0;
          unsel_low = 1'b0;
          sel       = cs_sel;
          active    = 1'b1;
        end
      end
      prev_sclk = sclk;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, d1, tb0;
    bit seen;
    start = 1'b0; cs_sel = 1'b0; tx_data = '0;
    start_b = 1'b0; cs_b = 1'b0; txb = '0;

    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ce0", ce0, 1);
    chk("rst_ce1", ce1, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", int'(rx_data), 0);
    chk("rst_b_idle", int'({sclk_b, mosi_b, ce0_b, ce1_b, busy_b, done_b}), 6'b001100);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    mode = 0;
    run_xfer(8'hA5, 1'b0, 8'hA5);
    mode = 1;
    run_xfer(8'hFF, 1'b1, 8'h3C);
    mode = 0;

    // start pulses in cycles 10 and 50 of a running transfer
    d0 = done_cnt;
    issue(8'h96, 1'b0, 8'h96);
    repeat (9) @(posedge clk); #1;
    tx_data = 8'h0F; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ign_timeout", 200);
    repeat (150) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);

    // back-to-back with start held high
    @(posedge clk); #1;
    tx_data = 8'h01; cs_sel = 1'b0; start = 1'b1;
    exp_q.push_back('{tx: 8'h01, rx: 8'h01, cs: 1'b0});
    exp_q.push_back('{tx: 8'h80, rx: 8'h80, cs: 1'b0});
    @(posedge clk); #1 tx_data = 8'h80;
    wait_done("b2b_first", 200);
    d1 = cyc;
    chk("b2b_ce_at_done", ce0, 1);
    @(negedge clk);
    chk("b2b_ce_low_after", ce0, 0);
    @(posedge clk); #1 start = 1'b0;
    wait_done("b2b_second", 200);
    chk("b2b_spacing", cyc - d1, 109);

    // reset in cycle 40 of a transfer
    @(posedge clk); #1;
    tx_data = 8'h33; cs_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) @(posedge clk); #2;
    chk("pre_rst_ce0", ce0, 0);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_ce0", ce0, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    chk("midrst_rx_cleared", int'(rx_data), 0);
    repeat (150) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    run_xfer(8'h5A, 1'b0, 8'h5A);

    // CLK_DIV=4, WIDTH=1 boundary
    @(posedge clk); #1;
    txb = 1'b1; cs_b = 1'b0; start_b = 1'b1;
    @(negedge clk);
    tb0 = cyc;
    @(posedge clk); #1 start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("b_done_timeout", 0, 1);
    else begin
      chk("b_latency", cyc - tb0, 17);
      chk("b_rx", int'(rxb), 1);
      chk("b_ce0_high_at_done", ce0_b, 1);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI controller (master) that drives the Raspberry-Pi-style four-wire bus (SCLK, MOSI, MISO, CE0/CE1) from the FPGA side. It generates SPI mode 0 transfers of WIDTH bits, MSB first, to one of two chip selects. It is the initiating end of the bus our SPI peripheral block answers, and is used to exercise that block on-board and to talk to external SPI devices. A simple start/busy/done handshake connects it to user logic.

## Interface

- CLK_DIV, 6: SCLK half-period in clk cycles; legal range 4..255.
- WIDTH, 8: bits per transfer; legal range 1..32.

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a transfer; sampled only while busy=0.
- cs_sel  input  1  0 selects CE0, 1 selects CE1; latched with start.
- tx_data  input  WIDTH  word to shift out; latched with start.
- rx_data  output  WIDTH  word shifted in; updated in the done cycle, held until the next done.
- busy  output  1  high from the cycle after start is accepted until the done cycle (exclusive).
- done  output  1  one-cycle pulse at end of transfer.
- SCLK  output  1  serial clock, idle low.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in.
- CE0  output  1  chip enable 0, active low.
- CE1  output  1  chip enable 1, active low.

## Operation

- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - SCLK=0, CE0=CE1=1, MOSI=0, busy=0.
  - start=1 latches tx_data and cs_sel, then moves to SETUP.
- SETUP:
  - Selected CE low.
  - MOSI = tx_data[WIDTH-1].
  - Lasts CLK_DIV cycles, then XFER.
- XFER:
  - 2*WIDTH half-periods of CLK_DIV cycles each, starting with SCLK high.
  - MISO is sampled on the clk edge that ends each high half-period, in the same edge SCLK falls, and shifted into the LSB of the rx shift register.
  - On that same edge MOSI advances to the next lower bit.
  - After the WIDTH-th falling edge, go to HOLD.
- HOLD:
  - SCLK=0, MOSI=0, CE still low.
  - Lasts CLK_DIV cycles.
  - Then CE goes high, rx_data is loaded, done=1, and the FSM returns to IDLE, all in one cycle.
- Only the selected CE ever goes low. The unselected CE stays high for the entire transfer.
- start while busy=1 is ignored and is not queued.
- start in the done cycle is accepted, giving back-to-back transfers with CE high for exactly 1 cycle between them.
- Half-period counter width is 8 bits. Bit counter width is clog2(WIDTH)+1.

## Timing

- Reset values (asynchronous assertion): SCLK=0, MOSI=0, CE0=1, CE1=1, busy=0, done=0, rx_data=0, FSM=IDLE.
- Reset mid-transfer: CE deasserts immediately, no done pulse, and the partial rx word is discarded.
- start sampled at cycle 0:
  - CE low at cycle 1.
  - First SCLK rise at cycle 1+CLK_DIV.
  - done and CE high at cycle N = 1 + CLK_DIV*(2*WIDTH+2).
- Defaults (CLK_DIV=6, WIDTH=8): N = 109.
- MISO setup margin: at least CLK_DIV-1 clk cycles after the preceding SCLK fall. This covers the peripheral's internal synchronizer latency of 3 cycles.
- done and busy are registered outputs. No combinational path runs from inputs to outputs.

## Structure

- Shared package spi_pkg holds:
  - FSM state encoding.
  - SPI mode constant (mode 0).
  - CLK_DIV_MIN = 4.
  - CE idle level constant (1).
- Sub-module spi_clkgen: half-period counter emitting rise_tick and fall_tick strobes plus the registered SCLK level, enabled only in XFER.
- The shift registers and FSM stay in spi_master.

## Test plan

- Loopback, CLK_DIV=6, WIDTH=8:
  - MISO tied to MOSI, start with tx_data=8'hA5, cs_sel=0.
  - Expect rx_data=8'hA5 and done at cycle 109.
  - CE1 stays high throughout.
  - Exactly 8 SCLK rises.
- Fixed responder, cs_sel=1:
  - Model drives 8'h3C MSB-first, changing on SCLK fall; tx_data=8'hFF.
  - Expect rx_data=8'h3C.
  - MOSI reads 1 at every SCLK rise.
  - CE0 never low.
- start pulsed in cycles 10 and 50 of an active transfer: ignored, a single done, and tx bits unchanged.
- Back-to-back:
  - start held high continuously with tx_data 8'h01 then 8'h80.
  - Two done pulses 109 cycles apart.
  - CE high for exactly 1 cycle between transfers.
- rst asserted at cycle 40 mid-transfer:
  - CE0 high, SCLK=0, busy=0 immediately, no done.
  - A following transfer of 8'h5A completes correctly.
- Boundary CLK_DIV=4, WIDTH=1, tx_data=1, MISO=1: done at cycle 17 and rx_data=1.
